fft_bank_wr_ctrl: RTL and testbench

Write-side controller for the two-bank FFT sample memory. It sits directly downstream of the lane permuter. For each frame it sequences pair indices and drives the permuter's lane-swap select so the permuted lanes land conflict-free in bank 0 and bank 1. It then registers the permuted data onto the two bank write ports. It handles both natural-order loads from the external input and stride-2^s write-back of butterfly results.

---
 rtl/fft_bank_wr_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_fft_bank_wr_ctrl.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_bank_wr_ctrl.sv
`timescale 1ns/1ps
// Write-side controller for the two-bank FFT sample memory: sequences pair indices,
// steers the permuter lane swap and registers permuted pairs onto both bank write ports.
// Optional macro WR_OUTREG_EN adds a second output register stage on the bank write ports.
module fft_bank_wr_ctrl #(
    parameter int N_LOG2 = 10,
    parameter int DW     = 64,
    parameter int SW     = 4
) (
    input  logic              CLK,
    input  logic              RSTn,
    input  logic              START,
    input  logic [SW-1:0]     STAGE,
    input  logic              IN_VALID,
    output logic              IN_READY,
    output logic              SEL_PERMW,
    input  logic [DW-1:0]     Q0_PERM,
    input  logic [DW-1:0]     Q1_PERM,
    output logic              B0_WE,
    output logic              B1_WE,
    output logic [N_LOG2-2:0] B0_ADDR,
    output logic [N_LOG2-2:0] B1_ADDR,
    output logic [DW-1:0]     B0_WDATA,
    output logic [DW-1:0]     B1_WDATA,
    output logic              BUSY,
    output logic              DONE
);

    localparam int            AW     = N_LOG2 - 1;
    localparam logic [AW-1:0] K_LAST = '1;
    localparam logic [SW-1:0] S_MAX  = SW'(AW);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_FIN   = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] k_q, k_d;
    logic [SW-1:0] s_q, s_d;

    logic [N_LOG2-1:0] idx_i, idx_j, bit_s;
    logic              bank_i;
    logic              accept;
    logic [AW-1:0]     addr0_d, addr1_d;

    // i = k with a zero spliced in at bit s; bits below s keep their place, bits above shift up.
    genvar gi;
    generate
        for (gi = 0; gi < N_LOG2; gi++) begin : g_ins
            logic k_lo, k_hi;
            if (gi < AW) begin : g_lo
                assign k_lo = k_q[gi];
            end else begin : g_lo0
                assign k_lo = 1'b0;
            end
            if (gi > 0) begin : g_hi
                assign k_hi = k_q[gi-1];
            end else begin : g_hi0
                assign k_hi = 1'b0;
            end
            assign bit_s[gi] = (SW'(gi) == s_q);
            assign idx_i[gi] = (SW'(gi) < s_q) ? k_lo : (bit_s[gi] ? 1'b0 : k_hi);
        end
    endgenerate

    assign idx_j  = idx_i | bit_s;
    assign bank_i = ^idx_i;
    assign accept = (state_q == ST_LOAD) && IN_VALID;

    // Whichever of i/j has even parity lands in bank 0.
    assign addr0_d = bank_i ? idx_j[N_LOG2-1:1] : idx_i[N_LOG2-1:1];
    assign addr1_d = bank_i ? idx_i[N_LOG2-1:1] : idx_j[N_LOG2-1:1];

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q <= ST_IDLE;
            k_q     <= '0;
            s_q     <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            s_q     <= s_d;
        end
    end

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        s_d     = s_q;
        case (state_q)
            ST_IDLE: begin
                if (START) begin
                    state_d = ST_LOAD;
                    k_d     = '0;
                    s_d     = (STAGE > S_MAX) ? S_MAX : STAGE;
                end
            end
            ST_LOAD: begin
                if (IN_VALID) begin
                    k_d = k_q + 1'b1;
                    if (k_q == K_LAST) begin
                        state_d = ST_FIN;
                    end
                end
            end
            ST_FIN: begin
`ifdef WR_OUTREG_EN
                state_d = ST_DRAIN;
`else
                state_d = ST_IDLE;
`endif
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign IN_READY  = (state_q == ST_LOAD);
    assign SEL_PERMW = (state_q == ST_LOAD) && bank_i;
    assign BUSY      = (state_q != ST_IDLE);
`ifdef WR_OUTREG_EN
    assign DONE      = (state_q == ST_DRAIN);
`else
    assign DONE      = (state_q == ST_FIN);
`endif

    logic          we_q;
    logic [AW-1:0] addr0_q, addr1_q;
    logic [DW-1:0] wdata0_q, wdata1_q;

    // Address and data only move on an accept so they hold between writes.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            we_q     <= 1'b0;
            addr0_q  <= '0;
            addr1_q  <= '0;
            wdata0_q <= '0;
            wdata1_q <= '0;
        end else begin
            we_q <= accept;
            if (accept) begin
                addr0_q  <= addr0_d;
                addr1_q  <= addr1_d;
                wdata0_q <= Q0_PERM;
                wdata1_q <= Q1_PERM;
            end
        end
    end

`ifdef WR_OUTREG_EN
    logic          we2_q;
    logic [AW-1:0] addr02_q, addr12_q;
    logic [DW-1:0] wdata02_q, wdata12_q;

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            we2_q     <= 1'b0;
            addr02_q  <= '0;
            addr12_q  <= '0;
            wdata02_q <= '0;
            wdata12_q <= '0;
        end else begin
            we2_q     <= we_q;
            addr02_q  <= addr0_q;
            addr12_q  <= addr1_q;
            wdata02_q <= wdata0_q;
            wdata12_q <= wdata1_q;
        end
    end

    assign B0_WE    = we2_q;
    assign B1_WE    = we2_q;
    assign B0_ADDR  = addr02_q;
    assign B1_ADDR  = addr12_q;
    assign B0_WDATA = wdata02_q;
    assign B1_WDATA = wdata12_q;
`else
    assign B0_WE    = we_q;
    assign B1_WE    = we_q;
    assign B0_ADDR  = addr0_q;
    assign B1_ADDR  = addr1_q;
    assign B0_WDATA = wdata0_q;
    assign B1_WDATA = wdata1_q;
`endif

endmodule

// File: tb/tb_fft_bank_wr_ctrl.sv
`timescale 1ns/1ps
// Bench for fft_bank_wr_ctrl at N_LOG2=4: table vectors from the index rules, corner
// sequences and random frames, all checked against an arithmetic pair/bank model.
module tb_fft_bank_wr_ctrl;

    localparam int NL = 4;
    localparam int AW = NL - 1;
    localparam int NP = 1 << AW;
    localparam int DW = 64;
    localparam int SW = 4;
`ifdef WR_OUTREG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          start = 1'b0;
    logic [SW-1:0] stage = '0;
    logic          in_valid = 1'b0;
    logic          in_ready, sel_permw;
    logic [DW-1:0] q0 = '0, q1 = '0;
    logic          b0_we, b1_we;
    logic [AW-1:0] b0_addr, b1_addr;
    logic [DW-1:0] b0_wdata, b1_wdata;
    logic          busy, done;

    fft_bank_wr_ctrl #(.N_LOG2(NL), .DW(DW), .SW(SW)) dut (
        .CLK(clk), .RSTn(rstn), .START(start), .STAGE(stage),
        .IN_VALID(in_valid), .IN_READY(in_ready), .SEL_PERMW(sel_permw),
        .Q0_PERM(q0), .Q1_PERM(q1),
        .B0_WE(b0_we), .B1_WE(b1_we), .B0_ADDR(b0_addr), .B1_ADDR(b1_addr),
        .B0_WDATA(b0_wdata), .B1_WDATA(b1_wdata), .BUSY(busy), .DONE(done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          k;
        int          a0;
        int          a1;
        logic [63:0] d0;
        logic [63:0] d1;
        int          due;
    } wr_t;

    typedef struct {
        logic [SW-1:0] stage;
        int            k;
        int            sel;
        int            a0;
        int            a1;
    } vec_t;

    wr_t exp_q[$];
    wr_t mon_e;
    int  obs_a0[NP], obs_a1[NP], obs_sel[NP];
    int  wr0_cnt[NP], wr1_cnt[NP];
    int  frame_writes = 0;
    int  n_checks = 0, n_pass = 0;

    int  m_k = 0, m_s = 0, m_done_cyc = -100;
    bit  m_loading = 0, m_pending = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic int f_i(input int k, input int s);
        return ((k >> s) << (s + 1)) | (k & ((1 << s) - 1));
    endfunction

    function automatic int f_bank(input int x);
        return $countones(x) & 1;
    endfunction

    // Monitor: every write must match the oldest expected pair on its due cycle.
    always @(negedge clk) begin
        if (rstn) begin
            if (b0_we || b1_we) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_we", {62'd0, b0_we, b1_we}, 64'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("b0_we", b0_we, 1);
                    chk("b1_we", b1_we, 1);
                    chk("wr_cycle", cyc, mon_e.due);
                    chk("b0_addr", b0_addr, mon_e.a0);
                    chk("b1_addr", b1_addr, mon_e.a1);
                    chk("b0_wdata", b0_wdata, mon_e.d0);
                    chk("b1_wdata", b1_wdata, mon_e.d1);
                    obs_a0[mon_e.k] = int'(b0_addr);
                    obs_a1[mon_e.k] = int'(b1_addr);
                    wr0_cnt[b0_addr]++;
                    wr1_cnt[b1_addr]++;
                    frame_writes++;
                    $display("write k=%0d b0_addr=%0d b1_addr=%0d cycle=%0d", mon_e.k, b0_addr, b1_addr, cyc);
                end
            end else if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
                chk("missed_we", b0_we, 1);
                void'(exp_q.pop_front());
            end
        end
    end

    // One clock of stimulus; called at posedge+1, returns at the next posedge+1.
    task automatic step(input bit v, input bit st, input logic [SW-1:0] stg);
        int i, j, exp_sel;
        if (m_pending && !m_loading && cyc > m_done_cyc) m_pending = 0;
        chk("in_ready", in_ready, m_loading);
        chk("busy", busy, m_pending);
        chk("done", done, (cyc == m_done_cyc));
        i = f_i(m_k, m_s);
        j = i | (1 << m_s);
        exp_sel = m_loading ? f_bank(i) : 0;
        chk("sel_permw", sel_permw, exp_sel);
        if (m_loading) obs_sel[m_k] = int'(sel_permw);
        start    = st;
        stage    = stg;
        in_valid = v;
        q0       = {$urandom, $urandom};
        q1       = {$urandom, $urandom};
        if (v && m_loading) begin
            exp_q.push_back('{k: m_k,
                              a0: (f_bank(i) == 0) ? (i >> 1) : (j >> 1),
                              a1: (f_bank(i) == 0) ? (j >> 1) : (i >> 1),
                              d0: q0, d1: q1, due: cyc + LAT});
            m_k++;
            if (m_k == NP) begin
                m_loading  = 0;
                m_done_cyc = cyc + LAT;
            end
        end
        if (st && !m_pending) begin
            m_pending = 1;
            m_loading = 1;
            m_k       = 0;
            m_s       = (int'(stg) > NL - 1) ? NL - 1 : int'(stg);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        #1;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_sel", sel_permw, 0);
        chk("rst_b0_we", b0_we, 0);
        chk("rst_b1_we", b1_we, 0);
        chk("rst_b0_addr", b0_addr, 0);
        chk("rst_b1_addr", b1_addr, 0);
        chk("rst_b0_wdata", b0_wdata, 0);
        chk("rst_b1_wdata", b1_wdata, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        exp_q.delete();
        m_loading  = 0;
        m_pending  = 0;
        m_k        = 0;
        m_done_cyc = -100;
        start      = 1'b0;
        in_valid   = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rstn = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // mode 0: back-to-back; 1: valid toggles; 2: random valid/start; 3: start held high.
    task automatic run_frame(input logic [SW-1:0] stg, input int mode);
        int n;
        bit v, st;
        n = 0;
        frame_writes = 0;
        for (int a = 0; a < NP; a++) begin
            wr0_cnt[a] = 0;
            wr1_cnt[a] = 0;
        end
        step(mode == 2, 1'b1, stg);
        while (m_loading && n < 200) begin
            case (mode)
                1:       begin v = (n % 2 == 0); st = 1'b0; end
                2:       begin v = 1'($urandom_range(0, 1)); st = ($urandom_range(0, 4) == 0); end
                3:       begin v = 1'b1; st = 1'b1; end
                default: begin v = 1'b1; st = 1'b0; end
            endcase
            step(v, st, SW'($urandom_range(0, 15)));
            n++;
        end
        if (m_loading) begin
            chk("frame_timeout", m_k, NP);
            do_reset();
        end
        repeat (LAT + 2) step((mode == 2) ? 1'($urandom_range(0, 1)) : 1'b0, 1'b0, stg);
        chk("frame_writes", frame_writes, NP);
        for (int a = 0; a < NP; a++) begin
            chk("b0_addr_once", wr0_cnt[a], 1);
            chk("b1_addr_once", wr1_cnt[a], 1);
        end
        $display("frame stage=%0d mode=%0d writes=%0d", stg, mode, frame_writes);
    endtask

    initial begin
        vec_t vecs[6];
        vecs[0] = '{stage: 4'd0, k: 0, sel: 0, a0: 0, a1: 0};
        vecs[1] = '{stage: 4'd0, k: 1, sel: 1, a0: 1, a1: 1};
        vecs[2] = '{stage: 4'd2, k: 0, sel: 0, a0: 0, a1: 2};
        vecs[3] = '{stage: 4'd2, k: 1, sel: 1, a0: 2, a1: 0};
        vecs[4] = '{stage: 4'd2, k: 4, sel: 1, a0: 6, a1: 4};
        vecs[5] = '{stage: 4'd7, k: 0, sel: 0, a0: 0, a1: 4};

        @(posedge clk);
        #1;
        do_reset();

        for (int r = 0; r < 6; r++) begin
            run_frame(vecs[r].stage, 0);
            chk("tbl_sel", obs_sel[vecs[r].k], vecs[r].sel);
            chk("tbl_b0_addr", obs_a0[vecs[r].k], vecs[r].a0);
            chk("tbl_b1_addr", obs_a1[vecs[r].k], vecs[r].a1);
            $display("vector %0d stage=%0d k=%0d sel=%0d b0=%0d b1=%0d", r, vecs[r].stage,
                     vecs[r].k, obs_sel[vecs[r].k], obs_a0[vecs[r].k], obs_a1[vecs[r].k]);
        end

        for (int s = 0; s < NL; s++) run_frame(SW'(s), 0);
        run_frame(4'd1, 1);
        run_frame(4'd2, 3);

        // Abort after the third accept, then a clean frame must restart at k=0.
        step(1'b0, 1'b1, 4'd0);
        repeat (3) step(1'b1, 1'b0, 4'd0);
        do_reset();
        run_frame(4'd0, 0);
        chk("post_rst_k0_b0", obs_a0[0], 0);
        chk("post_rst_k1_b0", obs_a0[1], 1);

        for (int f = 0; f < 30; f++) run_frame(SW'($urandom_range(0, 15)), 2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
